mem_lsu: RTL and testbench

- Load/store unit between the pipeline's MEM stage and the word-wide data DRAM (synchronous read, 1-cycle latency, no byte enables).
- Converts RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into DRAM word accesses.
- Sub-word stores use read-modify-write; loads are lane-extracted and sign/zero-extended.
- Stalls the pipeline while busy and returns load data with a one-cycle valid pulse.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_align.sv | 58 +++++
 rtl/mem_lsu.sv | 105 ++++++++++
 tb/tb_mem_lsu.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes and FSM state encoding.
package lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    localparam logic [2:0] STATE_IDLE      = 3'd0;
    localparam logic [2:0] STATE_LD_RD     = 3'd1;
    localparam logic [2:0] STATE_LD_DATA   = 3'd2;
    localparam logic [2:0] STATE_RMW_RD    = 3'd3;
    localparam logic [2:0] STATE_RMW_MERGE = 3'd4;
    localparam logic [2:0] STATE_ST_WR     = 3'd5;

    typedef enum logic [2:0] {
        IDLE      = STATE_IDLE,
        LD_RD     = STATE_LD_RD,
        LD_DATA   = STATE_LD_DATA,
        RMW_RD    = STATE_RMW_RD,
        RMW_MERGE = STATE_RMW_MERGE,
        ST_WR     = STATE_ST_WR
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend, sub-word store merge, request legality.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  fun3,
    output logic [31:0] load_data,
    output logic [31:0] new_word,
    input  logic        chk_we,
    input  logic [1:0]  chk_lane,
    input  logic [2:0]  chk_fun3,
    output logic        err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [3:0]  byte_hit;

    always_comb begin
        byte_sel  = rdata[{lane, 3'b000} +: 8];
        half_sel  = lane[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        case (fun3)
            LSU_B:   load_data = {{24{byte_sel[7]}}, byte_sel};
            LSU_H:   load_data = {{16{half_sel[15]}}, half_sel};
            LSU_BU:  load_data = {24'd0, byte_sel};
            LSU_HU:  load_data = {16'd0, half_sel};
            default: load_data = rdata;
        endcase
    end

    // Half stores place wdata[7:0] in the even byte and wdata[15:8] in the odd byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign byte_hit[gi] = ((fun3 == LSU_B) && (lane == LANE)) ||
                                  ((fun3 == LSU_H) && (lane[1] == LANE[1]));
            assign new_word[8*gi +: 8] = byte_hit[gi] ?
                ((fun3 == LSU_H) ? wdata[8*(gi%2) +: 8] : wdata[7:0]) :
                rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        err = 1'b0;
        case (chk_fun3)
            LSU_B:   err = 1'b0;
            LSU_H:   err = chk_lane[0];
            LSU_W:   err = (chk_lane != 2'b00);
            LSU_BU:  err = chk_we;
            LSU_HU:  err = chk_we | chk_lane[0];
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: turns byte/half/word requests into word DRAM accesses with RMW for sub-word stores.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_fun3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              stall,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              req_err,
    output logic [ADDR_W-3:0] dram_addr,
    output logic              dram_we,
    output logic [31:0]       dram_wdata,
    input  logic [31:0]       dram_rdata
);

    lsu_state_e        state_reg, state_next;
    logic [2:0]        fun3_reg;
    logic [1:0]        lane_reg;
    logic [ADDR_W-3:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       rdata_reg;
    logic              rsp_valid_reg;
    logic              err_reg;
    logic              accept, go, err_now;
    logic [31:0]       load_data, new_word;

    lsu_align u_align (
        .rdata     (dram_rdata),
        .wdata     (wdata_reg),
        .lane      (lane_reg),
        .fun3      (fun3_reg),
        .load_data (load_data),
        .new_word  (new_word),
        .chk_we    (req_we),
        .chk_lane  (req_addr[1:0]),
        .chk_fun3  (req_fun3),
        .err       (err_now)
    );

    assign req_ready  = (state_reg == IDLE) & ~rst;
    assign accept     = req_valid & req_ready;
    assign go         = accept & ~err_now;
    assign stall      = ((state_reg != IDLE) | go) & ~rst;
    assign dram_we    = (state_reg == ST_WR) & ~rst;
    assign dram_addr  = addr_reg;
    assign dram_wdata = wdata_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_rdata  = rdata_reg;
    assign req_err    = err_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (go) begin
                    if (!req_we)                 state_next = LD_RD;
                    else if (req_fun3 == LSU_W)  state_next = ST_WR;
                    else                         state_next = RMW_RD;
                end
            end
            LD_RD:     state_next = LD_DATA;
            LD_DATA:   state_next = IDLE;
            RMW_RD:    state_next = RMW_MERGE;
            RMW_MERGE: state_next = ST_WR;
            ST_WR:     state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            fun3_reg      <= 3'd0;
            lane_reg      <= 2'd0;
            addr_reg      <= '0;
            wdata_reg     <= 32'd0;
            rdata_reg     <= 32'd0;
            rsp_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            err_reg       <= accept & err_now;
            rsp_valid_reg <= (state_reg == LD_DATA);
            if (go) begin
                fun3_reg  <= req_fun3;
                lane_reg  <= req_addr[1:0];
                addr_reg  <= req_addr[ADDR_W-1:2];
                wdata_reg <= req_wdata;
            end
            if (state_reg == LD_DATA)   rdata_reg <= load_data;
            // The merged word reuses the store-data register so ST_WR drives it unchanged.
            if (state_reg == RMW_MERGE) wdata_reg <= new_word;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a registered-read DRAM model and per-transaction cycle tracking.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_fun3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        req_err;
    logic [29:0] dram_addr;
    logic        dram_we;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata;

    logic [31:0] mem [64];
    logic        bd_we;
    logic [5:0]  bd_addr;
    logic [31:0] bd_data;

    int n_checks = 0;
    int n_fail   = 0;

    int          we_cnt, we_cyc, rsp_cnt, rsp_cyc, err_cnt, err_cyc, ready_cyc;
    logic [6:0]  stall_mask;
    logic [29:0] addr1, we_addr;
    logic [31:0] we_data, rd_data;

    mem_lsu #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_fun3   (req_fun3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .stall      (stall),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .req_err    (req_err),
        .dram_addr  (dram_addr),
        .dram_we    (dram_we),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bd_we)        mem[bd_addr] <= bd_data;
        else if (dram_we) mem[dram_addr[5:0]] <= dram_wdata;
        dram_rdata <= mem[dram_addr[5:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [5:0] a, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // Issues one request at posedge+1 and records what happens over cycles 0..6.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        we_cnt = 0; rsp_cnt = 0; err_cnt = 0;
        we_cyc = -1; rsp_cyc = -1; err_cyc = -1; ready_cyc = -1;
        stall_mask = '0; addr1 = '0; we_addr = '0; we_data = '0; rd_data = '0;
        req_valid = 1'b1; req_we = we; req_fun3 = f3; req_addr = a; req_wdata = d;
        for (int k = 0; k < 7; k++) begin
            #1;
            if (stall) stall_mask[k] = 1'b1;
            if (k == 1) addr1 = dram_addr;
            if (dram_we) begin
                we_cnt++;
                if (we_cyc < 0) begin we_cyc = k; we_addr = dram_addr; we_data = dram_wdata; end
            end
            if (rsp_valid) begin
                rsp_cnt++;
                if (rsp_cyc < 0) begin rsp_cyc = k; rd_data = rsp_rdata; end
            end
            if (req_err) begin
                err_cnt++;
                if (err_cyc < 0) err_cyc = k;
            end
            if (k >= 1 && req_ready && ready_cyc < 0) ready_cyc = k;
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
        $display("TXN we=%0d fun3=%0d addr=%h wdata=%h we_cyc=%0d rsp_cyc=%0d err_cyc=%0d rdata=%h",
                 we, f3, a, d, we_cyc, rsp_cyc, err_cyc, rd_data);
    endtask

    task automatic exp_load(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
        run_req(1'b0, f3, a, 32'd0);
        check({tag, "_rsp_cyc"}, 32'(rsp_cyc), 32'd3);
        check({tag, "_rsp_cnt"}, 32'(rsp_cnt), 32'd1);
        check({tag, "_rdata"}, rd_data, exp);
        check({tag, "_stall"}, 32'(stall_mask), 32'h07);
        check({tag, "_addr1"}, 32'(addr1), 32'(a[31:2]));
        check({tag, "_we_cnt"}, 32'(we_cnt), 32'd0);
    endtask

    task automatic exp_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] exp, input int wc);
        run_req(1'b1, f3, a, d);
        check({tag, "_we_cnt"}, 32'(we_cnt), 32'd1);
        check({tag, "_we_cyc"}, 32'(we_cyc), 32'(wc));
        check({tag, "_we_addr"}, 32'(we_addr), 32'(a[31:2]));
        check({tag, "_we_data"}, we_data, exp);
        check({tag, "_ready_cyc"}, 32'(ready_cyc), 32'(wc + 1));
        check({tag, "_stall"}, 32'(stall_mask), 32'((1 << (wc + 1)) - 1));
        check({tag, "_rsp_cnt"}, 32'(rsp_cnt), 32'd0);
    endtask

    task automatic exp_err(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a);
        run_req(we, f3, a, 32'h12345678);
        check({tag, "_err_cyc"}, 32'(err_cyc), 32'd1);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'd1);
        check({tag, "_stall"}, 32'(stall_mask), 32'd0);
        check({tag, "_we_cnt"}, 32'(we_cnt), 32'd0);
        check({tag, "_rsp_cnt"}, 32'(rsp_cnt), 32'd0);
        check({tag, "_ready_cyc"}, 32'(ready_cyc), 32'd1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_fun3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_err", 32'(req_err), 32'd0);
        check("rst_we", 32'(dram_we), 32'd0);
        check("rst_outs", rsp_rdata | dram_wdata | 32'(dram_addr), 32'd0);
        rst = 1'b0;
        poke(6'd4, 32'h8081F2F3);
        poke(6'd8, 32'h11223344);
        poke(6'd9, 32'h00000000);

        exp_load("lw10",  LSU_W_F3(), 32'h10, 32'h8081F2F3);
        exp_load("lb13",  3'b000, 32'h13, 32'hFFFFFF80);
        exp_load("lbu13", 3'b100, 32'h13, 32'h00000080);
        exp_load("lh10",  3'b001, 32'h10, 32'hFFFFF2F3);
        exp_load("lhu12", 3'b101, 32'h12, 32'h00008081);
        exp_load("lb11",  3'b000, 32'h11, 32'hFFFFFFF2);

        exp_store("sb21", 3'b000, 32'h21, 32'h000000AB, 32'h1122AB44, 3);
        poke(6'd8, 32'h11223344);
        exp_store("sh22", 3'b001, 32'h22, 32'h0000BEEF, 32'hBEEF3344, 3);
        exp_store("sw24", 3'b010, 32'h24, 32'hDEADBEEF, 32'hDEADBEEF, 1);
        exp_load("lw24",  3'b010, 32'h24, 32'hDEADBEEF);

        exp_err("lh11",  1'b0, 3'b001, 32'h11);
        exp_err("sw26",  1'b1, 3'b010, 32'h26);
        exp_err("f3_011", 1'b0, 3'b011, 32'h10);
        exp_err("sbu",   1'b1, 3'b100, 32'h10);

        // Reset in RMW_MERGE must suppress the pending write.
        poke(6'd8, 32'h11223344);
        req_valid = 1'b1; req_we = 1'b1; req_fun3 = 3'b000; req_addr = 32'h21; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstmid_ready", 32'(req_ready), 32'd0);
        check("rstmid_stall", 32'(stall), 32'd0);
        check("rstmid_we", 32'(dram_we), 32'd0);
        check("rstmid_rsp", 32'(rsp_valid), 32'd0);
        check("rstmid_outs", rsp_rdata | dram_wdata | 32'(dram_addr), 32'd0);
        rst = 1'b0;
        we_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (dram_we) we_cnt++;
            @(posedge clk); #1;
        end
        check("rstmid_no_we", 32'(we_cnt), 32'd0);
        check("rstmid_mem", mem[8], 32'h11223344);
        $display("TXN reset_during_rmw we_cnt=%0d mem8=%h", we_cnt, mem[8]);

        // Back-to-back loads: second one issued in the first one's rsp_valid cycle.
        req_valid = 1'b1; req_we = 1'b0; req_fun3 = 3'b010; req_addr = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        req_valid = 1'b1; req_addr = 32'h24;
        #1;
        check("b2b_rsp1", 32'(rsp_valid), 32'd1);
        check("b2b_rdata1", rsp_rdata, 32'h8081F2F3);
        check("b2b_ready", 32'(req_ready), 32'd1);
        check("b2b_stall", 32'(stall), 32'd1);
        rsp_cyc = -1;
        for (int k = 1; k < 7; k++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            #1;
            if (rsp_valid && rsp_cyc < 0) begin rsp_cyc = k; rd_data = rsp_rdata; end
        end
        check("b2b_rsp2_cyc", 32'(rsp_cyc), 32'd3);
        check("b2b_rdata2", rd_data, 32'hDEADBEEF);
        $display("TXN back_to_back rsp2_cyc=%0d rdata=%h", rsp_cyc, rd_data);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    function automatic logic [2:0] LSU_W_F3();
        return 3'b010;
    endfunction

endmodule
